// File: rtl/serial_byte_transmitter.sv
// UART-style serializer: start bit, LSB-first data, optional even parity, stop bit(s).
// Words arrive on a valid/ready handshake. All outputs come straight from registers.
module serial_byte_transmitter #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic                  parity_r, parity_s;
  logic                  serial_r, serial_s;
  logic                  ready_r, busy_r, done_r, done_s;

  // State register plus registered copies of every output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      idx_r    <= IDX_ZERO;
      shift_r  <= {DATA_WIDTH{1'b0}};
      parity_r <= 1'b0;
      serial_r <= 1'b1;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      parity_r <= parity_s;
      serial_r <= serial_s;
      ready_r  <= (state_s == ST_IDLE);
      busy_r   <= (state_s != ST_IDLE);
      done_r   <= done_s;
    end
  end

  // Next-state logic; serial_s is the line level for the upcoming cycle.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    shift_s  = shift_r;
    parity_s = parity_r;
    serial_s = serial_r;
    case (state_r)
      ST_IDLE: begin
        serial_s = 1'b1;
        if (tx_valid && ready_r) begin
          shift_s  = tx_data;
          parity_s = even_parity(tx_data);
          state_s  = ST_START;
          cnt_s    = CNT_LOAD;
          idx_s    = IDX_ZERO;
          serial_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_ZERO) begin
          state_s  = ST_DATA;
          cnt_s    = CNT_LOAD;
          idx_s    = IDX_ZERO;
          serial_s = shift_r[0];
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if (idx_r != DATA_LAST) begin
          // Shift so the bit on the line is always shift_r[0].
          shift_s  = {1'b0, shift_r[DATA_WIDTH-1:1]};
          serial_s = shift_r[1];
          idx_s    = idx_r + IDX_ONE;
          cnt_s    = CNT_LOAD;
        end else if (PARITY_EN != 0) begin
          state_s  = ST_PARITY;
          serial_s = parity_r;
          cnt_s    = CNT_LOAD;
        end else begin
          state_s  = ST_STOP;
          serial_s = 1'b1;
          idx_s    = IDX_ZERO;
          cnt_s    = CNT_LOAD;
        end
      end
      ST_PARITY: begin
        if (cnt_r == CNT_ZERO) begin
          state_s  = ST_STOP;
          serial_s = 1'b1;
          idx_s    = IDX_ZERO;
          cnt_s    = CNT_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_STOP: begin
        serial_s = 1'b1;
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if (idx_r != STOP_LAST) begin
          idx_s = idx_r + IDX_ONE;
          cnt_s = CNT_LOAD;
        end else begin
          state_s = ST_IDLE;
          idx_s   = IDX_ZERO;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        cnt_s    = CNT_ZERO;
        idx_s    = IDX_ZERO;
        serial_s = 1'b1;
      end
    endcase
    // The final stop cycle is the only one where the counter sits at zero on the last stop bit.
    done_s = (state_s == ST_STOP) && (cnt_s == CNT_ZERO) && (idx_s == STOP_LAST);
  end

  assign tx_serial = serial_r;
  assign tx_ready  = ready_r;
  assign tx_busy   = busy_r;
  assign tx_done   = done_r;

endmodule
